// File: rtl/dmem_mmio.sv
// dmem_mmio: data memory with word RAM, output FIFO and timer/compare interrupt behind an MMIO block
// Ports: clk, reset (sync, active-high); memwrite/addr/wdata store side and rdata combinational load;
//        out_data/out_valid/out_ready FIFO drain; timer_irq sticky compare interrupt.
// Build option: define MMIO_TIMER_EN to include the timer (TIMER_CNT, TIMER_CMP, IRQ_STAT, timer_irq).
module dmem_mmio #(
  parameter int RAM_WORDS = 64,
  parameter int FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        timer_irq
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] fifo [FIFO_DEPTH];
  logic [FW-1:0] rd_ptr, wr_ptr;
  logic [FW:0] count;
  logic overflow, is_ram, is_mmio, wr_mmio, full, pop, push_req, push, ovf_set;
  logic [5:0] reg_sel;
  logic [31:0] cnt, cmp, stat;
  logic unused;
  assign is_ram = addr[31:AW+2] == '0;
  assign is_mmio = addr[31:8] == MMIO_BASE[31:8];
  assign reg_sel = addr[7:2];
  assign wr_mmio = memwrite && is_mmio && !is_ram;
  assign full = count == (FW+1)'(FIFO_DEPTH);
  assign pop = out_valid && out_ready;
  assign push_req = wr_mmio && reg_sel == 6'h00;
  // a pop in the same cycle frees the slot the push lands in, so a full FIFO still accepts
  assign push = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;
  assign out_valid = count != '0;
  assign out_data = fifo[rd_ptr];
  assign stat = {16'b0, 8'(count), 5'b0, overflow, full, !out_valid};
  assign rdata = is_ram ? ram[addr[AW+1:2]] :
                 !is_mmio ? '0 :
                 reg_sel == 6'h01 ? stat :
                 reg_sel == 6'h02 ? cnt :
                 reg_sel == 6'h03 ? cmp :
                 reg_sel == 6'h04 ? {31'b0, timer_irq} : '0;
  assign unused = ^addr[1:0];
  always_ff @(posedge clk)
    if (memwrite && is_ram) ram[addr[AW+1:2]] <= wdata;
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + FW'(1);
      if (push) wr_ptr <= wr_ptr + FW'(1);
      count <= count + (FW+1)'(push) - (FW+1)'(pop);
      overflow <= ovf_set || (overflow && !(wr_mmio && reg_sel == 6'h01 && wdata[2]));
    end
  end
`ifdef MMIO_TIMER_EN
  logic irq;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      cmp <= '1;
      irq <= 1'b0;
    end else begin
      cnt <= (wr_mmio && reg_sel == 6'h02) ? wdata : cnt + 32'd1;
      if (wr_mmio && reg_sel == 6'h03) cmp <= wdata;
      // match on the pre-edge count; a set beats a same-cycle clear
      irq <= (cnt == cmp) || (irq && !(wr_mmio && reg_sel == 6'h04 && wdata[0]));
    end
  end
  assign timer_irq = irq;
`else
  assign cnt = '0;
  assign cmp = '0;
  assign timer_irq = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed stimulus with a queue/array reference model checked every cycle
module tb_dmem_mmio;
  localparam logic [31:0] MB = 32'hFFFF_0000;
  localparam logic [31:0] FD = MB;
  localparam logic [31:0] FS = MB + 32'h4;
  localparam logic [31:0] TC = MB + 32'h8;
  localparam logic [31:0] TM = MB + 32'hC;
  localparam logic [31:0] IS = MB + 32'h10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic memwrite = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] addr = FS;
  logic [31:0] wdata = '0;
  logic [31:0] rdata, out_data;
  logic out_valid, timer_irq;
  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];
  bit movf, mirq, armed;
  logic [31:0] mcnt, mcmp;
  logic [31:0] mram [64];
  bit mvalid [64];
  bit m_pop, m_push, m_ovf, m_mm;
  logic [31:0] e_rd;
  bit e_known;

  dmem_mmio dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr), .wdata(wdata),
    .rdata(rdata), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a, output bit known);
    logic [31:0] st;
    known = 1'b1;
    st = {16'b0, 8'(q.size()), 5'b0, movf, q.size() == 8, q.size() == 0};
    if (a < 32'd256) begin
      known = mvalid[a[7:2]];
      return mram[a[7:2]];
    end
    if (a[31:8] != 24'hFFFF00) return '0;
    case (a[7:2])
      6'd1: return st;
`ifdef MMIO_TIMER_EN
      6'd2: return mcnt;
      6'd3: return mcmp;
      6'd4: return {31'b0, mirq};
`endif
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      movf = 1'b0;
      mcnt = '0;
      mcmp = '1;
      mirq = 1'b0;
      armed = 1'b1;
    end else begin
      m_mm = addr[31:8] == 24'hFFFF00;
      m_pop = q.size() != 0 && out_ready;
      m_push = memwrite && m_mm && addr[7:2] == 6'd0;
      m_ovf = m_push && q.size() == 8 && !m_pop;
      if (m_pop) void'(q.pop_front());
      if (m_push && !m_ovf) q.push_back(wdata);
      if (m_ovf) movf = 1'b1;
      else if (memwrite && m_mm && addr[7:2] == 6'd1 && wdata[2]) movf = 1'b0;
`ifdef MMIO_TIMER_EN
      if (mcnt == mcmp) mirq = 1'b1;
      else if (memwrite && m_mm && addr[7:2] == 6'd4 && wdata[0]) mirq = 1'b0;
      mcnt = (memwrite && m_mm && addr[7:2] == 6'd2) ? wdata : mcnt + 32'd1;
      if (memwrite && m_mm && addr[7:2] == 6'd3) mcmp = wdata;
`endif
    end
    if (memwrite && addr < 32'd256) begin
      mram[addr[7:2]] = wdata;
      mvalid[addr[7:2]] = 1'b1;
    end
  end

  always @(negedge clk) if (armed) begin
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) chk("out_data", out_data, q[0]);
    chk("timer_irq", timer_irq, mirq);
    e_rd = exp_rd(addr, e_known);
    if (e_known) chk("rdata", rdata, e_rd);
  end

  task automatic cyc(input bit mw, input logic [31:0] a, input logic [31:0] d, input bit rdy);
    memwrite = mw;
    addr = a;
    wdata = d;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stat", rdata, 32'h1);
    chk("rst_valid", out_valid, 0);
    cyc(1, 32'h10, 32'hDEADBEEF, 0);
    cyc(0, 32'h10, 0, 0);
    @(negedge clk) chk("ram_rd", rdata, 32'hDEADBEEF);
    cyc(0, 32'h13, 0, 0);
    @(negedge clk) chk("ram_rd_bytes", rdata, 32'hDEADBEEF);
    cyc(1, 32'hFC, 32'h12345678, 0);
    cyc(0, 32'hFC, 0, 0);
    @(negedge clk) chk("ram_last", rdata, 32'h12345678);
    cyc(1, 32'h1000, 32'hFFFFFFFF, 0);
    cyc(0, 32'h1000, 0, 0);
    @(negedge clk) chk("unmapped", rdata, 0);
    cyc(0, 32'h100, 0, 0);
    @(negedge clk) chk("ram_end", rdata, 0);
    cyc(0, MB + 32'h14, 0, 0);
    @(negedge clk) chk("mmio_hole", rdata, 0);
    for (int i = 1; i <= 8; i++) cyc(1, FD, i, 0);
    cyc(0, FS, 0, 0);
    @(negedge clk) chk("stat_full", rdata, 32'h802);
    cyc(1, FD, 9, 0);
    cyc(0, FS, 0, 0);
    @(negedge clk) chk("stat_ovf", rdata, 32'h806);
    cyc(1, FS, 4, 0);
    cyc(0, FS, 0, 0);
    @(negedge clk) chk("stat_ovf_clr", rdata, 32'h802);
    chk("head_1", out_data, 1);
    cyc(0, FD, 0, 0);
    @(negedge clk) chk("fifo_data_rd", rdata, 0);
    cyc(1, FD, 32'h55, 1);
    cyc(0, FS, 0, 0);
    @(negedge clk) chk("stat_pushpop", rdata, 32'h802);
    chk("head_2", out_data, 2);
    for (int i = 0; i < 7; i++) cyc(0, FS, 0, 1);
    @(negedge clk) chk("last_55", out_data, 32'h55);
    cyc(0, FS, 0, 1);
    @(negedge clk) chk("drained_valid", out_valid, 0);
    chk("drained_stat", rdata, 32'h1);
    cyc(1, FD, 32'hA, 1);
    @(negedge clk) chk("ab_first", out_data, 32'hA);
    cyc(1, FD, 32'hB, 1);
    @(negedge clk) chk("ab_second", out_data, 32'hB);
    cyc(0, FS, 0, 1);
    @(negedge clk) chk("ab_empty", out_valid, 0);
    cyc(1, TC, 0, 0);
    cyc(1, TM, 5, 0);
    repeat (3) cyc(0, TC, 0, 0);
`ifdef MMIO_TIMER_EN
    @(negedge clk) chk("cnt_4", rdata, 4);
`endif
    cyc(0, TC, 0, 0);
    @(negedge clk) chk("irq_before", timer_irq, 0);
    cyc(0, TC, 0, 0);
`ifdef MMIO_TIMER_EN
    @(negedge clk) chk("irq_rise", timer_irq, 1);
    chk("cnt_6", rdata, 6);
`endif
    cyc(1, IS, 1, 0);
    cyc(0, IS, 0, 0);
    @(negedge clk) chk("irq_clr", timer_irq, 0);
    cyc(1, TC, 32'hFFFFFFFF, 0);
`ifdef MMIO_TIMER_EN
    @(negedge clk) chk("cnt_max", rdata, 32'hFFFFFFFF);
`endif
    cyc(0, TC, 0, 0);
    @(negedge clk) chk("cnt_wrap", rdata, 0);
    cyc(1, TC, 3, 0);
    for (int i = 0; i < 3; i++) cyc(1, FD, 32'h11 + i, 0);
    cyc(0, FS, 0, 0);
`ifdef MMIO_TIMER_EN
    @(negedge clk) chk("irq_pre_rst", timer_irq, 1);
`endif
    @(negedge clk) chk("stat_3", rdata, 32'h300);
    reset = 1'b1;
    memwrite = 1'b0;
    addr = FS;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk) chk("rst_mid_stat", rdata, 32'h1);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_irq", timer_irq, 0);
    cyc(0, TM, 0, 0);
`ifdef MMIO_TIMER_EN
    @(negedge clk) chk("rst_cmp", rdata, 32'hFFFFFFFF);
`else
    @(negedge clk) chk("cmp_absent", rdata, 0);
`endif
    cyc(0, 32'h10, 0, 0);
    @(negedge clk) chk("ram_kept", rdata, 32'hDEADBEEF);
    repeat (3) cyc(0, FS, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
Data-memory stage directly downstream of the single-cycle MIPS core. It consumes the core's memwrite, aluout (address) and writedata, and returns readdata combinationally in the same cycle. It combines a word RAM with a memory-mapped region containing an output FIFO (drained over valid/ready) and a free-running timer with a compare interrupt.

Parameters:
RAM_WORDS, 64, number of 32-bit RAM words; power of 2, minimum 4
FIFO_DEPTH, 8, output FIFO entries; power of 2, range 2..128
MMIO_BASE, 32'hFFFF_0000, base address of the MMIO register block

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
memwrite  in  1  store strobe from the core
addr  in  32  byte address (core aluout); addr[1:0] ignored
wdata  in  32  store data (core writedata)
rdata  out  32  load data (core readdata); combinational
out_data  out  32  FIFO head word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data
timer_irq  out  1  sticky timer-match interrupt

Behaviour:
- Decode, word-aligned:
  - RAM when addr < 4*RAM_WORDS; index = addr[log2(RAM_WORDS)+1:2].
  - MMIO when addr[31:8] == MMIO_BASE[31:8]; offset = addr[7:0].
  - Everything else is unmapped: reads return 0, writes are ignored.
- RAM: asynchronous read; write on the rising clk edge when memwrite is high. RAM contents are not reset.
- MMIO map, by offset:
  - 0x00 FIFO_DATA: a write pushes wdata. Reads return 0.
  - 0x04 FIFO_STAT: read = {16'b0, count[7:0], 5'b0, overflow, full, empty}. A write with wdata[2]=1 clears overflow.
  - 0x08 TIMER_CNT: read/write. A write loads the counter.
  - 0x0C TIMER_CMP: read/write.
  - 0x10 IRQ_STAT: read bit0 = timer_irq. A write with wdata[0]=1 clears it.
  - Other offsets read 0; writes to them are ignored.
- rdata is purely combinational from addr and current register/RAM state. Latency is 0 cycles. Stores take effect at the next edge.
- FIFO:
  - pop = out_valid && out_ready.
  - A push is accepted when count < FIFO_DEPTH, or when pop occurs in the same cycle.
  - A push into a full FIFO with no pop is dropped and sets sticky overflow.
  - Simultaneous push and pop on a non-full FIFO leaves count unchanged.
  - out_data = storage[rd_ptr]; its value is don't-care while empty.
  - Read and write pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
  - out_valid = (count != 0).
  - If overflow is set and cleared in the same cycle, set wins.
- Timer:
  - cnt increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - A TIMER_CNT write takes precedence over the increment.
  - timer_irq sets at the edge where the pre-edge cnt == cmp, and stays set until cleared.
  - If irq is set and cleared in the same cycle, set wins.
- Reset (synchronous) values:
  - FIFO emptied (pointers and count = 0); out_valid=0, overflow=0.
  - cnt=0, cmp=0xFFFF_FFFF, timer_irq=0.
  - Reset mid-operation discards all FIFO contents at that edge.
  - RAM is untouched by reset.

Optional Feature:
MMIO_TIMER_EN
- Defined: timer, TIMER_CNT, TIMER_CMP, IRQ_STAT and timer_irq behave as specified above.
- Undefined: no timer logic is built. Offsets 0x08, 0x0C and 0x10 read 0 and ignore writes. timer_irq is tied to 0.

Test Plan:
- RAM store/load: write 0xDEADBEEF to addr 0x10, then read 0x10 -> 0xDEADBEEF. Read 0x13 -> same word. Read 0x0000_1000 (unmapped) -> 0.
- FIFO fill and overflow, out_ready=0:
  - Push 1..8 -> STAT = count 8, full=1, empty=0.
  - 9th push -> dropped; overflow=1; count stays 8.
  - Write STAT with 0x4 -> overflow=0.
- FIFO drain/ordering: push 0xA, 0xB with out_ready=1 -> out_data sequence 0xA then 0xB, one per cycle. out_valid falls after the 2nd pop.
- Full with simultaneous push+pop: FIFO full, out_ready=1, push 0x55 -> accepted; count stays 8; 0x55 emerges last.
- Timer (MMIO_TIMER_EN defined):
  - Write CMP=5, CNT=0 -> timer_irq rises at the edge where cnt transitions 5 -> 6.
  - Write IRQ_STAT with 1 -> cleared.
  - CNT=0xFFFF_FFFF -> reads 0 next cycle.
- Reset mid-operation: FIFO holding 3 entries with irq set, assert reset 1 cycle -> out_valid=0, STAT=0x1, timer_irq=0, CMP reads 0xFFFF_FFFF. Previously written RAM word unchanged.
